// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : state of the word arriving on instr_i (BOOT/RUN/DROP)
//   if_id_t       : IF/ID pipeline register payload {pc, instr, valid}
//   make_bubble() : builds an invalid IF/ID entry carrying the NOP encoding
package fetch_pkg;

  // BOOT: first fetch after reset, no data yet on instr_i.
  // RUN : instr_i carries the word for ifq_pc.
  // DROP: instr_i carries a wrong-path word fetched before a redirect.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Width of PC / imem byte address. The IF/ID payload is sized from this,
  // so fetch_unit's PC_W must stay equal to it.
  localparam int PC_W_DEF = 9;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [31:0]         instr;
    logic                valid;
  } if_id_t;

  function automatic if_id_t make_bubble(input logic [31:0] nop);
    if_id_t b;
    b.pc    = '0;
    b.instr = nop;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk   : core clock
//   reset : asynchronous, active-low; loads a bubble
//   load  : capture d
//   flush : replace contents with a bubble (wins over load)
//   d     : candidate entry from the fetch stage
//   q     : current IF/ID contents
// With neither load nor flush the register holds (stall).
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= make_bubble(BUBBLE_INSTR);
    end else if (flush) begin
      q <= make_bubble(BUBBLE_INSTR);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 5-stage RV32I core.
// Owns the PC, drives the synchronous instruction memory (1-cycle read
// latency) and fills the IF/ID register, squashing wrong-path words after
// a branch redirect.
//   clk, reset      : core clock; asynchronous active-low reset
//   stall_i         : hazard stall, holds PC / fetch / IF/ID
//   pc_sel_i        : branch taken, redirect to br_pc_i (beats stall)
//   br_pc_i         : branch target byte address
//   instr_i         : imem read data for the address presented last cycle
//   imem_addr_o     : imem byte address (= pc)
//   imem_en_o       : imem read enable
//   if_id_pc_o      : PC of the instruction in IF/ID
//   if_id_instr_o   : instruction in IF/ID
//   if_id_valid_o   : IF/ID holds a real instruction
//   bad_target_o    : sticky flag, a redirect target was misaligned/out of range
//   redirect_cnt_o  : saturating count of redirects
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          PC_W      = fetch_pkg::PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             pc_sel_i,
  input  logic [31:0]      br_pc_i,
  input  logic [31:0]      instr_i,
  output logic [PC_W-1:0]  imem_addr_o,
  output logic             imem_en_o,
  output logic [PC_W-1:0]  if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             bad_target_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  fetch_state_e    state_q;
  fetch_state_e    state_next;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] ifq_pc_q;
  logic            bad_target_q;
  logic [CNT_W-1:0] redirect_cnt_q;
  logic            load_id;
  logic            flush_id;
  logic            advance;
  logic            target_out_of_range;
  logic            target_bad;
  logic [PC_W-1:0] target_pc;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  // Redirect beats stall; only an unstalled, non-redirect cycle advances.
  assign advance   = !pc_sel_i && !stall_i;
  assign target_pc = {br_pc_i[PC_W-1:2], 2'b00};

  // Any set bit above the imem address range makes the target unreachable.
  if (PC_W < 32) begin : g_range
    assign target_out_of_range = |br_pc_i[31:PC_W];
  end else begin : g_full
    assign target_out_of_range = 1'b0;
  end

  assign target_bad = (br_pc_i[1:0] != 2'b00) || target_out_of_range;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    if (pc_sel_i) begin
      state_next = DROP;
    end else if (!stall_i) begin
      state_next = RUN;
    end
  end

  // IF/ID control: only a RUN-state word is real; everything else becomes
  // a bubble when the stage moves, and the register holds on stall.
  always_comb begin
    load_id  = 1'b0;
    flush_id = 1'b0;
    if (pc_sel_i) begin
      flush_id = 1'b1;
    end else if (!stall_i) begin
      if (state_q == RUN) begin
        load_id = 1'b1;
      end else begin
        flush_id = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ PC path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ifq_pc_q <= '0;
    end else if (pc_sel_i) begin
      pc_q <= target_pc;
    end else if (advance) begin
      pc_q     <= pc_q + PC_W'(4);
      ifq_pc_q <= pc_q;
    end
  end

  // ------------------------------------------------ status / statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bad_target_q   <= 1'b0;
      redirect_cnt_q <= '0;
    end else if (pc_sel_i) begin
      if (target_bad) begin
        bad_target_q <= 1'b1;
      end
      if (!(&redirect_cnt_q)) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------- IF/ID reg
  always_comb begin
    if_id_d.pc    = ifq_pc_q;
    if_id_d.instr = instr_i;
    if_id_d.valid = 1'b1;
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .reset(reset),
    .load (load_id),
    .flush(flush_id),
    .d    (if_id_d),
    .q    (if_id_q)
  );

  // ------------------------------------------------------------ outputs
  // The memory keeps reading RESET_PC while reset is held so the first
  // word is ready as soon as reset releases.
  assign imem_en_o      = !reset || !stall_i || pc_sel_i;
  assign imem_addr_o    = pc_q;
  assign if_id_pc_o     = if_id_q.pc;
  assign if_id_instr_o  = if_id_q.instr;
  assign if_id_valid_o  = if_id_q.valid;
  assign bad_target_o   = bad_target_q;
  assign redirect_cnt_o = redirect_cnt_q;

endmodule
